// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the core-RAM to req/ack bus bridge.
`default_nettype none

package mem_bus_bridge_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    BRG_IDLE = 2'b00,
    BRG_BUSY = 2'b01,
    BRG_DONE = 2'b10
  } brg_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_bridge_timeout_cnt.sv
// Wait-state counter for the bridge; expired flags the last permitted BUSY cycle.
`default_nettype none

module mem_bus_bridge_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == LAST);

  // Holding at LAST keeps the count from ever wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_bridge.sv
// Turns the core's single-cycle data-RAM access into a registered req/ack bus
// transaction with wait states and timeout, stalling the pipeline throughout.
`default_nettype none

module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [SEL_W-1:0]  ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);

  brg_state_t state;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       expired;

  assign cnt_clear  = (state != BRG_BUSY);
  assign cnt_enable = (state == BRG_BUSY) && !bus_ack_i;

  mem_bus_bridge_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  // IDLE passes ram_ce_i straight through so the core stalls in the request cycle.
  always_comb begin
    stallreq_o = 1'b0;
    if (rst) begin
      case (state)
        BRG_IDLE: stallreq_o = ram_ce_i;
        BRG_BUSY: stallreq_o = 1'b1;
        default:  stallreq_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BRG_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      ram_data_o  <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        BRG_IDLE: begin
          if (ram_ce_i) begin
            bus_we_o    <= ram_we_i;
            bus_sel_o   <= ram_sel_i;
            bus_addr_o  <= ram_addr_i;
            bus_wdata_o <= ram_data_i;
            bus_req_o   <= 1'b1;
            state       <= BRG_BUSY;
          end
        end
        BRG_BUSY: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              ram_data_o <= bus_rdata_i;
            end
            state <= BRG_DONE;
          end else if (expired) begin
            bus_req_o  <= 1'b0;
            ram_data_o <= '0;
            bus_err_o  <= 1'b1;
            state      <= BRG_DONE;
          end
        end
        BRG_DONE: begin
          state <= BRG_IDLE;
        end
        default: begin
          state <= BRG_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: per-cycle expectations derived from the
// access latency rules, compared on every falling edge, plus literal pins.
`default_nettype none

module tb_mem_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_bus_bridge #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (TO),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_ce_i    (ram_ce_i),
    .ram_we_i    (ram_we_i),
    .ram_sel_i   (ram_sel_i),
    .ram_addr_i  (ram_addr_i),
    .ram_data_i  (ram_data_i),
    .ram_data_o  (ram_data_o),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_o   (bus_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected output values for the current cycle.
  logic        chk = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_err;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  // Event counters sampled on the falling edge.
  int req_cycles = 0, req_rises = 0, err_pulses = 0, stall_cycles = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus_req_o) req_cycles++;
    if (bus_req_o && !prev_req) req_rises++;
    prev_req = bus_req_o;
    if (bus_err_o) err_pulses++;
    if (stallreq_o) stall_cycles++;
    if (chk) begin
      check("stallreq", 32'(stallreq_o), 32'(exp_stall));
      check("bus_req",  32'(bus_req_o),  32'(exp_req));
      check("bus_we",   32'(bus_we_o),   32'(exp_we));
      check("bus_sel",  32'(bus_sel_o),  32'(exp_sel));
      check("bus_addr", bus_addr_o,      exp_addr);
      check("bus_wdata", bus_wdata_o,    exp_wdata);
      check("ram_data", ram_data_o,      exp_rdata);
      check("bus_err",  32'(bus_err_o),  32'(exp_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit spurious_ack);
    step();
    ram_ce_i    = 1'b0;
    bus_ack_i   = spurious_ack;
    bus_rdata_i = 32'hBADBAD00;
    exp_stall   = 1'b0;
    exp_req     = 1'b0;
    exp_err     = 1'b0;
  endtask

  // One access: request in cycle 0, ack k cycles into BUSY (k<0 = never), then DONE.
  task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                        input bit ack_in_done);
    bit tmo;
    int busy_len;
    tmo      = !(k >= 0 && k < TO);
    busy_len = tmo ? TO : k + 1;
    step();
    ram_ce_i   = 1'b1;
    ram_we_i   = we;
    ram_sel_i  = sel;
    ram_addr_i = addr;
    ram_data_i = wdata;
    bus_ack_i  = 1'b0;
    exp_stall  = 1'b1;
    exp_req    = 1'b0;
    exp_err    = 1'b0;
    for (int c = 1; c <= busy_len; c++) begin
      step();
      ram_we_i    = ~we;
      ram_sel_i   = ~sel;
      ram_addr_i  = $urandom;
      ram_data_i  = $urandom;
      bus_ack_i   = (!tmo && c == busy_len);
      bus_rdata_i = bus_ack_i ? rdata : $urandom;
      exp_stall   = 1'b1;
      exp_req     = 1'b1;
      exp_we      = we;
      exp_sel     = sel;
      exp_addr    = addr;
      exp_wdata   = wdata;
      exp_err     = 1'b0;
    end
    step();
    bus_ack_i   = ack_in_done;
    bus_rdata_i = 32'h99999999;
    if (tmo) exp_rdata = 32'h0;
    else if (!we) exp_rdata = rdata;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_err   = tmo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_req, s_rise, s_err, s_stall;
    rst = 1'b0;
    ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = '0; ram_addr_i = '0; ram_data_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
    exp_sel = '0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1'b0);

    // Zero-wait read.
    s_req = req_cycles; s_stall = stall_cycles;
    access(1'b0, 4'hF, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    idle(1'b0);
    check("t1_rdata_lit", ram_data_o, 32'hDEADBEEF);
    check("t1_req_cycles", 32'(req_cycles - s_req), 32'd1);
    check("t1_stall_cycles", 32'(stall_cycles - s_stall), 32'd2);

    // Write with 3 wait states; ack coincides with the last counter value.
    s_req = req_cycles; s_err = err_pulses;
    access(1'b1, 4'b0011, 32'h204, 32'h12345678, 3, 32'hCAFEF00D, 1'b0);
    idle(1'b0);
    check("t2_rdata_kept", ram_data_o, 32'hDEADBEEF);
    check("t2_req_cycles", 32'(req_cycles - s_req), 32'd4);
    check("t2_no_err", 32'(err_pulses - s_err), 32'd0);

    // Timeout with no ack.
    s_req = req_cycles; s_err = err_pulses;
    access(1'b0, 4'hF, 32'h300, 32'h0, -1, 32'h0, 1'b0);
    idle(1'b0);
    check("t3_req_cycles", 32'(req_cycles - s_req), 32'd4);
    check("t3_err_pulses", 32'(err_pulses - s_err), 32'd1);
    check("t3_rdata_zero", ram_data_o, 32'h0);

    // Zero byte-enable write is still issued.
    access(1'b1, 4'h0, 32'h208, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
    idle(1'b0);

    // Reset in the second BUSY cycle.
    s_err = err_pulses;
    step();
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h400; ram_data_i = 32'h0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_sel = 4'hF; exp_addr = 32'h400; exp_wdata = 32'h0;
    step();
    #2 rst = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_sel = '0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_err = 1'b0;
    #1;
    check("t4_req_async", 32'(bus_req_o), 32'd0);
    check("t4_stall_async", 32'(stallreq_o), 32'd0);
    check("t4_addr_async", bus_addr_o, 32'h0);
    check("t4_rdata_async", ram_data_o, 32'h0);
    step();
    ram_ce_i = 1'b0;
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    check("t4_no_err", 32'(err_pulses - s_err), 32'd0);

    // Back-to-back reads with spurious acks in IDLE and DONE.
    s_rise = req_rises;
    idle(1'b1);
    access(1'b0, 4'hF, 32'h500, 32'h0, 0, 32'h1, 1'b1);
    check("t5_first_lit", ram_data_o, 32'h1);
    access(1'b0, 4'hF, 32'h504, 32'h0, 1, 32'h2, 1'b0);
    check("t5_second_lit", ram_data_o, 32'h2);
    idle(1'b1);
    idle(1'b0);
    check("t5_req_pulses", 32'(req_rises - s_rise), 32'd2);

    @(posedge clk);
    chk = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
